gpio_apb_irq: RTL and testbench

- Parametrised APB3 GPIO peripheral, successor to the fixed 8-bit input-only port.
- Per-pin direction, output data, synchronised input sampling, rising/falling edge detection, sticky W1C interrupt status and one level interrupt line.
- Sits on the APB bus beside the other peripherals; the pads and tristate buffers live in the top level and are driven from outPort/oe.

---
 rtl/gpio_pkg.sv | 18 +
 rtl/gpio_edge_sync.sv | 46 ++++
 rtl/gpio_apb_irq.sv | 110 +++++++++++
 tb/tb_gpio_apb_irq.sv | 200 ++++++++++++++++++++
 4 files changed

// File: rtl/gpio_pkg.sv
// Shared definitions for the APB GPIO block: register indices, bus FSM states
// and the synchroniser depth limit.
package gpio_pkg;

    localparam logic [2:0] GPIO_MODE = 3'd0;
    localparam logic [2:0] GPIO_ODR  = 3'd1;
    localparam logic [2:0] GPIO_IDR  = 3'd2;
    localparam logic [2:0] GPIO_IER  = 3'd3;
    localparam logic [2:0] GPIO_RISE = 3'd4;
    localparam logic [2:0] GPIO_FALL = 3'd5;
    localparam logic [2:0] GPIO_ISR  = 3'd6;
    localparam logic [2:0] GPIO_RSVD = 3'd7;

    localparam int SYNC_MAX = 4;

    typedef enum logic {IDLE, DONE} apb_state_e;

endpackage

// File: rtl/gpio_edge_sync.sv
// Input synchroniser, edge-history flop and post-reset arm counter.
// rise/fall are raw edges, not yet masked by the enable or direction registers.
module gpio_edge_sync
    import gpio_pkg::*;
#(
    parameter int WIDTH       = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic             PCLK,
    input  logic             PRESET,
    input  logic [WIDTH-1:0] in_pins,
    output logic [WIDTH-1:0] sync,
    output logic [WIDTH-1:0] rise,
    output logic [WIDTH-1:0] fall
);

    localparam int NSTG = (SYNC_STAGES < 2) ? 2 :
                          (SYNC_STAGES > SYNC_MAX) ? SYNC_MAX : SYNC_STAGES;
    localparam logic [2:0] ARM_N = 3'(NSTG + 1);

    logic [WIDTH-1:0] sync_p [NSTG];
    logic [WIDTH-1:0] prev;
    logic [2:0]       arm_cnt;
    logic             armed;

    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            for (int i = 0; i < NSTG; i++) sync_p[i] <= '0;
            prev    <= '0;
            arm_cnt <= '0;
        end else begin
            sync_p[0] <= in_pins;
            for (int i = 1; i < NSTG; i++) sync_p[i] <= sync_p[i-1];
            prev <= sync_p[NSTG-1];
            if (!armed) arm_cnt <= arm_cnt + 3'd1;
        end
    end

    // History is zero straight after reset, so edges are ignored until the
    // pipeline has been refilled from the real pins.
    assign armed = (arm_cnt == ARM_N);
    assign sync  = sync_p[NSTG-1];
    assign rise  = armed ? (sync & ~prev) : '0;
    assign fall  = armed ? (~sync & prev) : '0;

endmodule

// File: rtl/gpio_apb_irq.sv
// APB3 GPIO peripheral: direction/output registers, synchronised inputs,
// edge-triggered sticky W1C status and a level interrupt.
module gpio_apb_irq
    import gpio_pkg::*;
#(
    parameter int WIDTH       = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic             PCLK,
    input  logic             PRESET,
    input  logic [4:0]       PADDR,
    input  logic [31:0]      PWDATA,
    input  logic             PWRITE,
    input  logic             PENABLE,
    input  logic             PSEL,
    output logic [31:0]      PRDATA,
    output logic             PREADY,
    input  logic [WIDTH-1:0] inPort,
    output logic [WIDTH-1:0] outPort,
    output logic [WIDTH-1:0] oe,
    output logic             irq
);

    apb_state_e       state, state_nxt;
    logic [WIDTH-1:0] mode, odr, ier, rise_en, fall_en, isr;
    logic [WIDTH-1:0] sync, rise, fall, evt, clr, wdat;
    logic [2:0]       reg_sel;
    logic [31:0]      rdata;
    logic             wr_commit, rd_latch;
    logic             unused_bits;

    gpio_edge_sync #(.WIDTH(WIDTH), .SYNC_STAGES(SYNC_STAGES)) u_edge (
        .PCLK    (PCLK),
        .PRESET  (PRESET),
        .in_pins (inPort),
        .sync    (sync),
        .rise    (rise),
        .fall    (fall)
    );

    always_ff @(posedge PCLK) begin
        if (PRESET) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (PSEL && PENABLE) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    assign PREADY    = (state == DONE);
    assign reg_sel   = PADDR[4:2];
    assign wdat      = PWDATA[WIDTH-1:0];
    assign wr_commit = PSEL && PENABLE && PWRITE && PREADY;
    assign rd_latch  = (state == IDLE) && PSEL && PENABLE && !PWRITE;
    assign unused_bits = ^{PADDR[1:0], PWDATA};

    always_comb begin
        rdata = '0;
        case (reg_sel)
            GPIO_MODE: rdata[WIDTH-1:0] = mode;
            GPIO_ODR:  rdata[WIDTH-1:0] = odr;
            GPIO_IDR:  rdata[WIDTH-1:0] = sync;
            GPIO_IER:  rdata[WIDTH-1:0] = ier;
            GPIO_RISE: rdata[WIDTH-1:0] = rise_en;
            GPIO_FALL: rdata[WIDTH-1:0] = fall_en;
            GPIO_ISR:  rdata[WIDTH-1:0] = isr;
            default:   rdata = '0;
        endcase
    end

    // Output-mode pins are masked so driven pads never raise events.
    assign evt = ((rise & rise_en) | (fall & fall_en)) & ~mode;
    assign clr = (wr_commit && reg_sel == GPIO_ISR) ? wdat : '0;

    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            PRDATA  <= '0;
            mode    <= '0;
            odr     <= '0;
            ier     <= '0;
            rise_en <= '0;
            fall_en <= '0;
            isr     <= '0;
        end else begin
            if (rd_latch) PRDATA <= rdata;
            if (wr_commit) begin
                case (reg_sel)
                    GPIO_MODE: mode    <= wdat;
                    GPIO_ODR:  odr     <= wdat;
                    GPIO_IER:  ier     <= wdat;
                    GPIO_RISE: rise_en <= wdat;
                    GPIO_FALL: fall_en <= wdat;
                    default:   ;
                endcase
            end
            // A new event beats a simultaneous clear of the same bit.
            isr <= (isr & ~clr) | evt;
        end
    end

    assign outPort = odr;
    assign oe      = mode;
    assign irq     = |(isr & ier);

endmodule

// File: tb/tb_gpio_apb_irq.sv
// Self-checking bench for gpio_apb_irq: APB read scoreboard plus direct checks
// of the pin-side outputs and interrupt timing.
module tb_gpio_apb_irq;
    import gpio_pkg::*;

    localparam int WIDTH = 8;

    logic             PCLK = 1'b0;
    logic             PRESET;
    logic [4:0]       PADDR;
    logic [31:0]      PWDATA;
    logic             PWRITE;
    logic             PENABLE;
    logic             PSEL;
    logic [31:0]      PRDATA;
    logic             PREADY;
    logic [WIDTH-1:0] inPort;
    logic [WIDTH-1:0] outPort;
    logic [WIDTH-1:0] oe;
    logic             irq;

    int          n_vec = 0;
    int          n_err = 0;
    logic [31:0] exp_q [$];

    gpio_apb_irq #(.WIDTH(WIDTH), .SYNC_STAGES(2)) dut (
        .PCLK    (PCLK),
        .PRESET  (PRESET),
        .PADDR   (PADDR),
        .PWDATA  (PWDATA),
        .PWRITE  (PWRITE),
        .PENABLE (PENABLE),
        .PSEL    (PSEL),
        .PRDATA  (PRDATA),
        .PREADY  (PREADY),
        .inPort  (inPort),
        .outPort (outPort),
        .oe      (oe),
        .irq     (irq)
    );

    always #5 PCLK = ~PCLK;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge PCLK);
            #1;
        end
    endtask

    // Called just after a rising edge. fast=1 enters the access phase
    // immediately, letting a write land as early as possible after reset.
    task automatic apb_xfer(input bit wr, input logic [4:0] addr, input logic [31:0] wdata,
                            input bit fast, output logic [31:0] rdata);
        int waits;
        PSEL    = 1'b1;
        PWRITE  = wr;
        PADDR   = addr;
        PWDATA  = wdata;
        PENABLE = fast;
        if (!fast) begin
            step(1);
            PENABLE = 1'b1;
        end
        waits = 0;
        while (!PREADY && waits < 8) begin
            waits++;
            step(1);
        end
        if (!PREADY) check("pready_timeout", 32'(PREADY), 32'd1);
        else if (!fast) check("wait_states", 32'(waits), 32'd1);
        rdata = PRDATA;
        step(1);
        PSEL    = 1'b0;
        PENABLE = 1'b0;
        PWRITE  = 1'b0;
        check("pready_one_cycle", 32'(PREADY), 32'd0);
    endtask

    task automatic apb_write(input logic [4:0] addr, input logic [31:0] wdata);
        logic [31:0] rd;
        apb_xfer(1'b1, addr, wdata, 1'b0, rd);
    endtask

    task automatic apb_read(input string tag, input logic [4:0] addr, input logic [31:0] exp);
        logic [31:0] rd;
        exp_q.push_back(exp);
        apb_xfer(1'b0, addr, 32'h0, 1'b0, rd);
        check(tag, rd, exp_q.pop_front());
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] rd;
        PRESET = 1'b1; PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0;
        PADDR = '0; PWDATA = '0; inPort = '0;
        step(3);
        check("rst_pready", 32'(PREADY), 32'd0);
        check("rst_prdata", PRDATA, 32'd0);
        check("rst_outport", 32'(outPort), 32'd0);
        check("rst_oe", 32'(oe), 32'd0);
        check("rst_irq", 32'(irq), 32'd0);
        PRESET = 1'b0;
        step(5);

        for (int i = 0; i < 8; i++) apb_read("rst_reg", 5'(i * 4), 32'd0);

        apb_write(5'h00, 32'hFFFF_FFF0);
        apb_write(5'h04, 32'h0000_00A5);
        check("oe", 32'(oe), 32'h0000_00F0);
        check("outport", 32'(outPort), 32'h0000_00A5);
        apb_read("mode_rb", 5'h00, 32'h0000_00F0);
        apb_read("odr_rb", 5'h04, 32'h0000_00A5);
        check("prdata_hold_after_write", PRDATA, 32'h0000_00A5);
        apb_write(5'h08, 32'h0000_00FF);
        apb_read("idr_ro", 5'h08, 32'h0000_0000);
        apb_write(5'h1C, 32'hFFFF_FFFF);
        apb_read("rsvd", 5'h1C, 32'h0000_0000);
        apb_read("odr_addr_low_bits", 5'h07, 32'h0000_00A5);

        // Rising edge on pin 0: irq must rise exactly on the third edge.
        apb_write(5'h10, 32'h0000_0001);
        apb_write(5'h0C, 32'h0000_0001);
        inPort[0] = 1'b1;
        for (int k = 1; k <= 3; k++) begin
            step(1);
            check($sformatf("irq_rise_t%0d", k), 32'(irq), (k == 3) ? 32'd1 : 32'd0);
        end
        apb_read("isr_rise", 5'h18, 32'h0000_0001);
        apb_write(5'h18, 32'h0000_0001);
        check("irq_w1c", 32'(irq), 32'd0);
        apb_read("isr_w1c", 5'h18, 32'h0000_0000);

        // IDR latency: a read latched two edges after the change sees the old
        // value, one latched three edges after sees the new value.
        inPort[2] = 1'b1;
        apb_read("idr_t2", 5'h08, 32'h0000_0001);
        inPort[3] = 1'b1;
        step(1);
        apb_read("idr_t3", 5'h08, 32'h0000_000D);

        // Falling edge on pin 1 while masked.
        inPort[1] = 1'b1;
        step(4);
        apb_write(5'h14, 32'h0000_0002);
        inPort[1] = 1'b0;
        step(5);
        check("irq_masked", 32'(irq), 32'd0);
        apb_read("isr_fall", 5'h18, 32'h0000_0002);
        apb_write(5'h0C, 32'h0000_0002);
        check("irq_ier_enable", 32'(irq), 32'd1);
        apb_write(5'h18, 32'h0000_0002);
        check("irq_fall_clr", 32'(irq), 32'd0);

        // Output-mode pin never raises an event.
        apb_write(5'h10, 32'h0000_00F0);
        inPort[4] = 1'b1;
        step(5);
        apb_read("isr_outpin", 5'h18, 32'h0000_0000);

        // Rising edge on pin 0 lands on the same edge as a W1C of bit 0.
        apb_write(5'h10, 32'h0000_0001);
        inPort[0] = 1'b0;
        step(5);
        inPort[0] = 1'b1;
        apb_write(5'h18, 32'h0000_0001);
        apb_read("isr_set_wins", 5'h18, 32'h0000_0001);

        // Pins held high through reset; RISE enabled as early as possible.
        inPort = 8'hFF;
        PRESET = 1'b1;
        step(2);
        check("rst2_oe", 32'(oe), 32'd0);
        check("rst2_irq", 32'(irq), 32'd0);
        check("rst2_prdata", PRDATA, 32'd0);
        PRESET = 1'b0;
        apb_xfer(1'b1, 5'h10, 32'h0000_00FF, 1'b1, rd);
        step(6);
        apb_read("isr_armed", 5'h18, 32'h0000_0000);
        apb_read("rise_rb", 5'h10, 32'h0000_00FF);
        apb_read("idr_ff", 5'h08, 32'h0000_00FF);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
